// File: rtl/ahb_debug_master.sv
// ahb_debug_master: byte-stream command parser that drives single-word AHB-Lite transfers.
// Latency: last command byte -> NONSEQ next cycle; data-phase completion -> first tx byte next cycle.
// rx has no backpressure (bytes outside the parse states are dropped); tx holds data until tx_ready.
// Optional inter-byte receive timeout: define DBG_RX_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
module ahb_debug_master #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam logic [7:0] OP_WRITE      = 8'h57;
  localparam logic [7:0] OP_READ       = 8'h52;
  localparam logic [7:0] RSP_OK        = 8'h4B;
  localparam logic [7:0] RSP_ERR       = 8'h45;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_BUS_ADDR = 3'd3,
    S_BUS_DATA = 3'd4,
    S_SEND     = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_is_wr;     // latched opcode: 1 = write, 0 = read
  logic [1:0]  r_cnt;       // byte index within the address or data field
  logic [31:2] r_addr;      // word address; byte offset bits are never kept
  logic [31:0] r_wdata;
  logic [23:0] r_resp;      // read bytes still to be sent, next one in [7:0]
  logic [1:0]  r_left;      // response bytes remaining after the one on tx_data

  logic w_rx_is_op;
  logic w_last_byte;
  logic w_tmo_hit;

  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;

  assign w_rx_is_op  = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign w_last_byte = (r_cnt == 2'd3);

`ifdef DBG_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // Parameter is only meaningful with the timeout built in.
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_tmo_hit    = 1'b0;
`endif

  // Command parser, bus sequencer and response serializer in one registered FSM
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_is_wr  <= 1'b0;
      r_cnt    <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_resp   <= '0;
      r_left   <= 2'd0;
      HADDR    <= '0;
      HTRANS   <= HTRANS_IDLE;
      HWRITE   <= 1'b0;
      HWDATA   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
`ifdef DBG_RX_TIMEOUT_EN
      r_tmo    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid && w_rx_is_op) begin
            r_is_wr <= (rx_data == OP_WRITE);
            r_cnt   <= 2'd0;
            busy    <= 1'b1;
            r_state <= S_GET_ADDR;
`ifdef DBG_RX_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end

        S_GET_ADDR: begin
          if (rx_valid) begin
            case (r_cnt)
              2'd0:    r_addr[7:2]   <= rx_data[7:2];
              2'd1:    r_addr[15:8]  <= rx_data;
              2'd2:    r_addr[23:16] <= rx_data;
              default: r_addr[31:24] <= rx_data;
            endcase
            r_cnt <= r_cnt + 2'd1;
`ifdef DBG_RX_TIMEOUT_EN
            r_tmo <= '0;
`endif
            if (w_last_byte) begin
              if (r_is_wr) begin
                r_state <= S_GET_DATA;
              end else begin
                // A3 is on rx_data now; the address phase starts next cycle.
                HADDR   <= {rx_data, r_addr[23:2], 2'b00};
                HWRITE  <= 1'b0;
                HTRANS  <= HTRANS_NONSEQ;
                r_state <= S_BUS_ADDR;
              end
            end
          end else if (w_tmo_hit) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
`ifdef DBG_RX_TIMEOUT_EN
            r_tmo <= r_tmo + 1'b1;
`endif
          end
        end

        S_GET_DATA: begin
          if (rx_valid) begin
            r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data;
            r_cnt <= r_cnt + 2'd1;
`ifdef DBG_RX_TIMEOUT_EN
            r_tmo <= '0;
`endif
            if (w_last_byte) begin
              HADDR   <= {r_addr, 2'b00};
              HWRITE  <= 1'b1;
              HTRANS  <= HTRANS_NONSEQ;
              r_state <= S_BUS_ADDR;
            end
          end else if (w_tmo_hit) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
`ifdef DBG_RX_TIMEOUT_EN
            r_tmo <= r_tmo + 1'b1;
`endif
          end
        end

        S_BUS_ADDR: begin
          // Address-phase signals stay put until the slave side accepts them.
          if (HREADY) begin
            HTRANS  <= HTRANS_IDLE;
            if (r_is_wr) begin
              HWDATA <= r_wdata;
            end
            r_state <= S_BUS_DATA;
          end
        end

        S_BUS_DATA: begin
          if (HREADY) begin
            tx_valid <= 1'b1;
            if (HRESP) begin
              tx_data <= RSP_ERR;
              r_left  <= 2'd0;
            end else if (r_is_wr) begin
              tx_data <= RSP_OK;
              r_left  <= 2'd0;
            end else begin
              tx_data <= HRDATA[7:0];
              r_resp  <= HRDATA[31:8];
              r_left  <= 2'd3;
            end
            r_state <= S_SEND;
          end
        end

        S_SEND: begin
          // tx_valid is high for the whole of this state.
          if (tx_ready) begin
            if (r_left == 2'd0) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              tx_data <= r_resp[7:0];
              r_resp  <= {8'h00, r_resp[23:8]};
              r_left  <= r_left - 2'd1;
            end
          end
        end

        default: begin
          HTRANS   <= HTRANS_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_debug_master.sv
// Randomized bench for ahb_debug_master: AHB slave + tx sink models, reference command model.
module tb_ahb_debug_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;

  ahb_debug_master #(.TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } bus_t;

  bus_t        exp_bus[$];
  bus_t        obs_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];
  logic [7:0]  cmd_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int n_nonseq = 0;

  // Memory contents of never-written words, as the slave presents them.
  function automatic logic [31:0] bg(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- AHB slave model ----------------
  int          fixed_wait = -1;
  bit          addr_stall_en = 1'b0;
  bit          dp_active = 1'b0, dp_write = 1'b0, dp_err = 1'b0, dp_errstage = 1'b0;
  int          dp_wait = 0;
  logic [31:0] dp_addr = 32'h0;
  bit          chk_txv = 1'b0, as_pend = 1'b0;
  logic [31:0] as_addr = 32'h0;
  logic        as_write = 1'b0;

  always @(negedge HCLK) begin
    bus_t b;
    if (!HRESETn) begin
      dp_active = 1'b0; chk_txv = 1'b0; as_pend = 1'b0;
      HREADY = 1'b1; HRESP = 1'b0;
    end else begin
      if (chk_txv) begin
        n_cmp++;
        if (tx_valid !== 1'b1) begin
          n_bad++; $display("FAIL tx_after_dphase: tx_valid=%b required 1", tx_valid);
        end
        chk_txv = 1'b0;
      end
      if (as_pend) begin
        n_cmp++;
        if (HTRANS !== 2'b10 || HADDR !== as_addr || HWRITE !== as_write) begin
          n_bad++;
          $display("FAIL addr_hold: HTRANS=%b HADDR=%h HWRITE=%b required 10/%h/%b",
                   HTRANS, HADDR, HWRITE, as_addr, as_write);
        end
        as_pend = 1'b0;
      end
      HRESP  = 1'b0;
      HREADY = 1'b1;
      HRDATA = $urandom;
      if (dp_active) begin
        if (dp_err) begin
          HRESP = 1'b1;
          if (!dp_errstage) begin
            HREADY = 1'b0; dp_errstage = 1'b1;
          end else begin
            b.addr = dp_addr; b.wr = dp_write; b.wdata = dp_write ? HWDATA : 32'h0;
            obs_bus.push_back(b);
            dp_active = 1'b0; chk_txv = 1'b1;
          end
        end else if (dp_wait > 0) begin
          HREADY = 1'b0; dp_wait--;
        end else begin
          if (dp_write) slv_mem[dp_addr] = HWDATA;
          else HRDATA = slv_mem.exists(dp_addr) ? slv_mem[dp_addr] : bg(dp_addr);
          b.addr = dp_addr; b.wr = dp_write; b.wdata = dp_write ? HWDATA : 32'h0;
          obs_bus.push_back(b);
          dp_active = 1'b0; chk_txv = 1'b1;
        end
      end else if (addr_stall_en && $urandom_range(0, 2) == 0) begin
        HREADY = 1'b0;
      end
      if (HTRANS === 2'b10) begin
        if (HREADY) begin
          n_nonseq++;
          dp_active = 1'b1; dp_addr = HADDR; dp_write = HWRITE;
          dp_err = (HADDR[31:28] == 4'hE); dp_errstage = 1'b0;
          dp_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end else begin
          as_pend = 1'b1; as_addr = HADDR; as_write = HWRITE;
        end
      end
    end
  end

  // ---------------- tx sink ----------------
  bit         stall = 1'b0;
  bit         pend = 1'b0;
  logic [7:0] pend_dat = 8'h00;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      tx_ready = 1'b0; pend = 1'b0;
    end else begin
      if (pend) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== pend_dat) begin
          n_bad++;
          $display("FAIL tx_hold: tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, pend_dat);
        end
      end
      tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (tx_valid === 1'b1 && tx_ready) obs_tx.push_back(tx_data);
      pend = (tx_valid === 1'b1) && !tx_ready;
      pend_dat = tx_data;
    end
  end

  // ---------------- reference model and drivers ----------------
  // Expected bus transfer and response bytes, plus the command byte sequence.
  task automatic model_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    bus_t        b;
    logic [31:0] a, v;
    a = {addr[31:2], 2'b00};
    b.addr = a; b.wr = wr; b.wdata = wr ? data : 32'h0;
    exp_bus.push_back(b);
    if (a[31:28] == 4'hE) begin
      exp_tx.push_back(8'h45);
    end else if (wr) begin
      ref_mem[a] = data;
      exp_tx.push_back(8'h4B);
    end else begin
      v = ref_mem.exists(a) ? ref_mem[a] : bg(a);
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'((v >> (8 * i)) & 32'hFF));
    end
    cmd_q.delete();
    cmd_q.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) cmd_q.push_back(8'((addr >> (8 * i)) & 32'hFF));
    if (wr) for (int i = 0; i < 4; i++) cmd_q.push_back(8'((data >> (8 * i)) & 32'hFF));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge HCLK);
    rx_data = b; rx_valid = 1'b1;
    @(negedge HCLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      if (i != from) repeat ($urandom_range(0, 2)) @(negedge HCLK);
      send_byte(cmd_q[i]);
    end
  endtask

  task automatic check_nonseq(input bit wr, input logic [31:0] addr);
    n_cmp++;
    if (HTRANS !== 2'b10 || HADDR !== {addr[31:2], 2'b00} || HWRITE !== wr) begin
      n_bad++;
      $display("FAIL nonseq_next: HTRANS=%b HADDR=%h HWRITE=%b required 10/%h/%b",
               HTRANS, HADDR, HWRITE, {addr[31:2], 2'b00}, wr);
    end
  endtask

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data, input int junk);
    model_cmd(wr, addr, data);
    if (junk >= 0) send_byte(8'(junk));
    send_range(0, cmd_q.size());
    check_nonseq(wr, addr);
  endtask

  task automatic finish_cmd(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 400) begin
      @(negedge HCLK); k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_done: busy=%b required 0", name, busy);
    end
    repeat (2) @(negedge HCLK);
    n_cmp++;
    if (obs_bus.size() != exp_bus.size()) begin
      n_bad++; $display("FAIL %s_nxfer: got %0d required %0d", name, obs_bus.size(), exp_bus.size());
    end else begin
      for (int i = 0; i < exp_bus.size(); i++) begin
        n_cmp++;
        if (obs_bus[i] !== exp_bus[i]) begin
          n_bad++;
          $display("FAIL %s_xfer: got %h/%b/%h required %h/%b/%h", name, obs_bus[i].addr, obs_bus[i].wr,
                   obs_bus[i].wdata, exp_bus[i].addr, exp_bus[i].wr, exp_bus[i].wdata);
        end
      end
    end
    n_cmp++;
    if (obs_tx.size() != exp_tx.size()) begin
      n_bad++; $display("FAIL %s_ntx: got %0d required %0d", name, obs_tx.size(), exp_tx.size());
    end else begin
      for (int i = 0; i < exp_tx.size(); i++) begin
        n_cmp++;
        if (obs_tx[i] !== exp_tx[i]) begin
          n_bad++; $display("FAIL %s_tx%0d: got %h required %h", name, i, obs_tx[i], exp_tx[i]);
        end
      end
    end
    n_cmp++;
    if (HTRANS !== 2'b00) begin
      n_bad++; $display("FAIL %s_idle: HTRANS=%b required 00", name, HTRANS);
    end
    exp_bus.delete(); obs_bus.delete(); exp_tx.delete(); obs_tx.delete();
  endtask

  // ---------------- tests ----------------
  task automatic check_reset_vals(input string name);
    n_cmp++;
    if (HADDR !== 32'h0 || HWDATA !== 32'h0 || HTRANS !== 2'b00 || HWRITE !== 1'b0) begin
      n_bad++; $display("FAIL %s_bus: HADDR=%h HWDATA=%h HTRANS=%b HWRITE=%b required zeros", name, HADDR, HWDATA, HTRANS, HWRITE);
    end
    n_cmp++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_tx: tx_data=%h tx_valid=%b busy=%b required 00/0/0", name, tx_data, tx_valid, busy);
    end
  endtask

  task automatic test_reset();
    #3 HRESETn = 1'b0;
    #2 check_reset_vals("reset");
    n_cmp++;
    if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011) begin
      n_bad++; $display("FAIL reset_const: HSIZE=%b HBURST=%b HPROT=%b required 010/000/0011", HSIZE, HBURST, HPROT);
    end
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic test_write();
    fixed_wait = 0; addr_stall_en = 1'b0;
    issue_cmd(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, -1);
    finish_cmd("write");
  endtask

  task automatic test_read_wait();
    fixed_wait = 3; addr_stall_en = 1'b1;
    slv_mem[32'h2000_0004] = 32'h1234_5678;
    ref_mem[32'h2000_0004] = 32'h1234_5678;
    issue_cmd(1'b0, 32'h2000_0004, 32'h0, -1);
    finish_cmd("read_wait");
    addr_stall_en = 1'b0; fixed_wait = -1;
  endtask

  task automatic test_error();
    issue_cmd(1'b0, 32'hE000_0040, 32'h0, -1);
    finish_cmd("err_read");
    issue_cmd(1'b1, 32'hE000_0044, 32'h0BAD_F00D, -1);
    finish_cmd("err_write");
  endtask

  task automatic test_unaligned_junk();
    issue_cmd(1'b0, 32'h0000_0007, 32'h0, 8'hAA);
    finish_cmd("unaligned");
  endtask

  task automatic test_backpressure();
    int k;
    stall = 1'b1; fixed_wait = 1;
    issue_cmd(1'b0, 32'h2000_0008, 32'h0, -1);
    k = 0;
    while (tx_valid !== 1'b1 && k < 100) begin
      @(negedge HCLK); k++;
    end
    n_cmp++;
    if (tx_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_valid: tx_valid=%b required 1", tx_valid);
    end
    for (int i = 0; i < 5; i++) begin
      send_byte((i % 2 == 0) ? 8'h57 : 8'h52);
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== exp_tx[0]) begin
        n_bad++; $display("FAIL bp_hold: tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, exp_tx[0]);
      end
    end
    stall = 1'b0; fixed_wait = -1;
    finish_cmd("backpressure");
    issue_cmd(1'b1, 32'h2000_0008, 32'hCAFE_0001, -1);
    finish_cmd("resync_wr");
    issue_cmd(1'b0, 32'h2000_0008, 32'h0, -1);
    finish_cmd("resync_rd");
  endtask

  task automatic test_partial_idle();
    int ns0;
    ns0 = n_nonseq;
`ifdef DBG_RX_TIMEOUT_EN
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (20) @(negedge HCLK);
    n_cmp++;
    if (busy !== 1'b0 || n_nonseq != ns0 || HTRANS !== 2'b00) begin
      n_bad++; $display("FAIL timeout: busy=%b transfers=%0d required 0/0", busy, n_nonseq - ns0);
    end
    issue_cmd(1'b1, 32'h2000_0020, 32'h5555_AAAA, -1);
    finish_cmd("after_timeout");
`else
    model_cmd(1'b1, 32'h2000_0020, 32'h5555_AAAA);
    send_range(0, 3);
    repeat (20) @(negedge HCLK);
    n_cmp++;
    if (busy !== 1'b1 || n_nonseq != ns0) begin
      n_bad++; $display("FAIL no_timeout: busy=%b transfers=%0d required 1/0", busy, n_nonseq - ns0);
    end
    send_range(3, cmd_q.size());
    check_nonseq(1'b1, 32'h2000_0020);
    finish_cmd("slow_write");
`endif
  endtask

  task automatic test_reset_midflight();
    fixed_wait = 20;
    issue_cmd(1'b0, 32'h2000_0030, 32'h0, -1);
    repeat (4) @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1 check_reset_vals("midreset");
    exp_bus.delete(); obs_bus.delete(); exp_tx.delete(); obs_tx.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    fixed_wait = -1;
    repeat (2) @(negedge HCLK);
    issue_cmd(1'b1, 32'h2000_0034, 32'h0102_0304, -1);
    finish_cmd("post_reset");
  endtask

  task automatic test_random();
    bit          wr;
    logic [31:0] a, d;
    int          junk;
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = {4'hE, 28'($urandom)};
      else a = {4'h2, 22'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      d = $urandom;
      junk = -1;
      if ($urandom_range(0, 3) == 0) begin
        junk = int'($urandom_range(0, 255));
        if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
      end
      addr_stall_en = 1'($urandom_range(0, 1));
      issue_cmd(wr, a, d, junk);
      finish_cmd("random");
    end
    addr_stall_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_unaligned_junk();
    test_backpressure();
    test_partial_idle();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
